exec_sequencer: RTL

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

---
 rtl/exec_sequencer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/exec_sequencer.sv
// ---------------------------------------------------------------------------
// exec_sequencer
//
// Multi-cycle instruction sequencer. Fetches one instruction per pass from a
// combinational instruction ROM, hands it to an external decoder via InstReg,
// optionally waits on a data-memory handshake, then retires it: it raises the
// register-file write strobe and advances the program counter (sequential,
// absolute branch or relative branch). The all-ones instruction word is a
// halt: it parks the sequencer in DONE with Ack raised until the next Start.
//
// Per-instruction flow:  FETCH -> EXEC -> [MEM ...] -> WB -> FETCH
//   non-memory instruction : 3 cycles
//   memory instruction     : 4 cycles + one per MemReady=0 cycle in MEM
//
// Ports
//   Clk            in   single clock, rising edge
//   Reset          in   synchronous active-high reset (beats Start)
//   Start          in   (re)start from PC 0; overrides any in-flight work
//   InstAddress    out  [PCW] current PC, addresses the instruction ROM
//   Instruction    in   [IW]  ROM data for InstAddress (combinational)
//   InstReg        out  [IW]  latched instruction, drives external decoder
//   Jump           in   branch taken for InstReg
//   BranchAbsOrRel in   1 = relative target, 0 = absolute
//   Target         in   [PCW] branch target or two's-complement offset
//   MemAccess      in   InstReg is a load/store
//   MemWrite       in   InstReg is a store
//   RegWrite       in   InstReg writes the register file
//   MemReq         out  data-memory request (MEM state)
//   MemReady       in   data-memory completion, same cycle as MemReq
//   MemWrEn        out  data-memory write strobe
//   RegWrEn        out  register-file write strobe
//   CycleCt        out  [CTW] saturating count of active cycles since Start
//   InstCt         out  [CTW] saturating count of retired instructions
//   Ack            out  registered "program done" flag
// ---------------------------------------------------------------------------
module exec_sequencer #(
  parameter int PCW = 10,
  parameter int IW  = 9,
  parameter int CTW = 16
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  output logic [PCW-1:0] InstAddress,
  input  logic [IW-1:0]  Instruction,
  output logic [IW-1:0]  InstReg,
  input  logic           Jump,
  input  logic           BranchAbsOrRel,
  input  logic [PCW-1:0] Target,
  input  logic           MemAccess,
  input  logic           MemWrite,
  input  logic           RegWrite,
  output logic           MemReq,
  input  logic           MemReady,
  output logic           MemWrEn,
  output logic           RegWrEn,
  output logic [CTW-1:0] CycleCt,
  output logic [CTW-1:0] InstCt,
  output logic           Ack
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_MEM   = 3'd3;
  localparam logic [2:0] ST_WB    = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam logic [IW-1:0]  HALT_INST = {IW{1'b1}};
  localparam logic [CTW-1:0] CT_MAX    = {CTW{1'b1}};
  localparam logic [CTW-1:0] CT_ONE    = {{(CTW-1){1'b0}}, 1'b1};
  localparam logic [PCW-1:0] PC_ONE    = {{(PCW-1){1'b0}}, 1'b1};

  logic [2:0]     state_q,    state_d;
  logic [PCW-1:0] pc_q,       pc_d;
  logic [IW-1:0]  inst_q,     inst_d;
  logic [CTW-1:0] cycle_ct_q, cycle_ct_d;
  logic [CTW-1:0] inst_ct_q,  inst_ct_d;
  logic           ack_q,      ack_d;

  logic           active;
  logic [PCW-1:0] next_pc;

  // Cycles spent working on an instruction; IDLE and DONE are not counted.
  assign active = (state_q == ST_FETCH) || (state_q == ST_EXEC) ||
                  (state_q == ST_MEM)   || (state_q == ST_WB);

  // Relative targets are two's-complement offsets; the PCW-bit add wraps
  // modulo 2^PCW, which is exactly the required behaviour for both signs.
  assign next_pc = !Jump          ? pc_q + PC_ONE :
                   BranchAbsOrRel ? pc_q + Target : Target;

  always_comb begin
    // NOTE: every *_d starts as its *_q so any path that does not assign it
    // holds state; without these defaults the block would infer latches.
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    cycle_ct_d = cycle_ct_q;
    inst_ct_d  = inst_ct_q;
    ack_d      = ack_q;

    if (active && (cycle_ct_q != CT_MAX)) begin
      cycle_ct_d = cycle_ct_q + CT_ONE;
    end

    case (state_q)
      ST_IDLE: begin
        // Leaves only through Start, handled below.
      end
      ST_FETCH: begin
        inst_d  = Instruction;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (inst_q == HALT_INST) begin
          state_d = ST_DONE;
          ack_d   = 1'b1;
        end else if (MemAccess) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (MemReady) begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        pc_d    = next_pc;
        state_d = ST_FETCH;
        if (inst_ct_q != CT_MAX) begin
          inst_ct_d = inst_ct_q + CT_ONE;
        end
      end
      ST_DONE: begin
        // PC and counters frozen, Ack held.
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Start abandons whatever is in flight, from any state.
    if (Start) begin
      state_d    = ST_FETCH;
      pc_d       = '0;
      inst_d     = inst_q;
      cycle_ct_d = '0;
      inst_ct_d  = '0;
      ack_d      = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of evaluation order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      inst_q     <= '0;
      cycle_ct_q <= '0;
      inst_ct_q  <= '0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      cycle_ct_q <= cycle_ct_d;
      inst_ct_q  <= inst_ct_d;
      ack_q      <= ack_d;
    end
  end

  // Write strobes are suppressed in a cycle where Start or Reset is about to
  // abandon the instruction, so a discarded instruction never commits.
  assign MemReq  = (state_q == ST_MEM);
  assign MemWrEn = MemReq && MemWrite && MemReady && !Start && !Reset;
  assign RegWrEn = (state_q == ST_WB) && RegWrite && !Start && !Reset;

  assign InstAddress = pc_q;
  assign InstReg     = inst_q;
  assign CycleCt     = cycle_ct_q;
  assign InstCt      = inst_ct_q;
  assign Ack         = ack_q;

endmodule
